// File: rtl/prio_encoder_83_hs_pkg.sv
// Shared types and helpers for the sequential 8-to-3 priority encoder.
// The index helper is sized for the widest supported request vector.
package prio_encoder_83_hs_pkg;

    localparam int DEFAULT_N = 8;
    localparam int MAX_N     = 16;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // Highest set index wins; returns 0 for an all-zero vector.
    function automatic int prio_idx(input logic [MAX_N-1:0] vec);
        int result;
        result = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_encoder_83_hs_if.sv
// Request/handshake bundle between request sources, the encoder and its consumer.
// The master side drives requests and ready; the slave side is the encoder.
interface prio_encoder_83_hs_if
    import prio_encoder_83_hs_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    localparam int IDX_W = $clog2(N);

    logic             E;
    logic [N-1:0]     In_n;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] Y;
    logic             GS_n;
    logic             ovf;

    modport master (
        output E,
        output In_n,
        output out_ready,
        input  out_valid,
        input  Y,
        input  GS_n,
        input  ovf
    );

    modport slave (
        input  E,
        input  In_n,
        input  out_ready,
        output out_valid,
        output Y,
        output GS_n,
        output ovf
    );

endinterface

// File: rtl/prio_encoder_83_hs_comb.sv
// Purely combinational highest-bit encoder with an any-bit flag.
// Bit N-1 has the highest priority.
module prio_encoder_83_hs_comb
    import prio_encoder_83_hs_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [MAX_N-1:0] req_wide;

    always_comb begin
        req_wide = MAX_N'(req);
        idx      = IDX_W'(prio_idx(req_wide));
        any      = |req;
    end

endmodule

// File: rtl/prio_encoder_83_hs.sv
// Sticky-pending priority encoder: captures active-low requests and serves the
// highest pending index over a valid/ready handshake, retiring it on acceptance.
module prio_encoder_83_hs
    import prio_encoder_83_hs_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                clk,
    input  logic                rst,
    prio_encoder_83_hs_if.slave bus
);

    localparam int IDX_W = $clog2(N);

    state_t           state;
    state_t           next_state;

    logic [N-1:0]     pending;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     set_vec;
    logic [N-1:0]     clr_vec;

    logic [IDX_W-1:0] y_reg;
    logic [IDX_W-1:0] y_next;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    logic             valid_reg;
    logic             valid_next;
    logic             gs_n_reg;
    logic             gs_n_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             handshake;

    prio_encoder_83_hs_comb #(
        .N (N)
    ) u_enc (
        .req (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Set is applied after clear so a re-request on the retiring bit keeps it pending.
    always_comb begin
        handshake = valid_reg & bus.out_ready;
        set_vec   = bus.E ? ~bus.In_n : '0;
        clr_vec   = '0;
        if (handshake) begin
            clr_vec[y_reg] = 1'b1;
        end
        pending_next = (pending & ~clr_vec) | set_vec;
        ovf_next     = |(set_vec & pending & ~clr_vec);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Y is only loaded when leaving IDLE, so it stays frozen while presented.
    always_comb begin
        valid_next = valid_reg;
        y_next     = y_reg;
        case (state)
            IDLE: begin
                valid_next = enc_any;
                if (enc_any) begin
                    y_next = enc_idx;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    valid_next = 1'b0;
                end
            end
            default: valid_next = 1'b0;
        endcase
        gs_n_next = ~((|pending_next) | valid_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            gs_n_reg  <= 1'b1;
            ovf_reg   <= 1'b0;
        end else begin
            state     <= next_state;
            pending   <= pending_next;
            y_reg     <= y_next;
            valid_reg <= valid_next;
            gs_n_reg  <= gs_n_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.Y         = y_reg;
    assign bus.GS_n      = gs_n_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_prio_encoder_83_hs.sv
// Directed bench for prio_encoder_83_hs: hand-computed expectations checked
// with immediate assertions one cycle after each applied stimulus step.
module tb_prio_encoder_83_hs;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    prio_encoder_83_hs_if #(.N(8)) bus ();

    prio_encoder_83_hs #(
        .N (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] in_n,
                                 input logic ready);
        rst           = r;
        bus.E         = e;
        bus.In_n      = in_n;
        bus.out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [2:0] ey,
                               input logic eg, input logic eo);
        checks++;
        assert (bus.out_valid === ev) else begin
            fails++;
            $error("[TB] FAIL %s out_valid: observed %0b expected %0b", tag, bus.out_valid, ev);
        end
        checks++;
        assert (bus.Y === ey) else begin
            fails++;
            $error("[TB] FAIL %s Y: observed %0d expected %0d", tag, bus.Y, ey);
        end
        checks++;
        assert (bus.GS_n === eg) else begin
            fails++;
            $error("[TB] FAIL %s GS_n: observed %0b expected %0b", tag, bus.GS_n, eg);
        end
        checks++;
        assert (bus.ovf === eo) else begin
            fails++;
            $error("[TB] FAIL %s ovf: observed %0b expected %0b", tag, bus.ovf, eo);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst           = 1'b1;
        bus.E         = 1'b1;
        bus.In_n      = 8'hFF;
        bus.out_ready = 1'b0;

        // Reset then idle
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        checkOutput("reset", 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
            checkOutput("idle", 1'b0, 3'd0, 1'b1, 1'b0);
        end

        // Single request on bit 2
        applyStimulus(1'b0, 1'b1, 8'b1111_1011, 1'b1);
        checkOutput("single_capture", 1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("single_present", 1'b1, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("single_done", 1'b0, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("single_quiet", 1'b0, 3'd2, 1'b1, 1'b0);

        // Priority drain of bits 7, 5, 0
        applyStimulus(1'b0, 1'b1, 8'b0101_1110, 1'b1);
        checkOutput("drain_capture", 1'b0, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_y7", 1'b1, 3'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_gap1", 1'b0, 3'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_y5", 1'b1, 3'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_gap2", 1'b0, 3'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_y0", 1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("drain_empty", 1'b0, 3'd0, 1'b1, 1'b0);

        // Stability under backpressure
        applyStimulus(1'b0, 1'b1, 8'b1111_1101, 1'b0);
        checkOutput("bp_capture", 1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("bp_y1", 1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'b1011_1111, 1'b0);
        checkOutput("bp_hold_a", 1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("bp_hold_b", 1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("bp_accept", 1'b0, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("bp_y6", 1'b1, 3'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("bp_empty", 1'b0, 3'd6, 1'b1, 1'b0);

        // Overflow and set-wins on bit 4
        applyStimulus(1'b0, 1'b1, 8'b1110_1111, 1'b0);
        checkOutput("ovf_capture", 1'b0, 3'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("ovf_y4", 1'b1, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'b1110_1111, 1'b0);
        checkOutput("ovf_pulse", 1'b1, 3'd4, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("ovf_clear", 1'b1, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'b1110_1111, 1'b1);
        checkOutput("setwins_hs", 1'b0, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("setwins_again", 1'b1, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("setwins_empty", 1'b0, 3'd4, 1'b1, 1'b0);

        // Capture disabled
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("en_off_a", 1'b0, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("en_off_b", 1'b0, 3'd4, 1'b1, 1'b0);

        // Reset while presenting with three requests pending
        applyStimulus(1'b0, 1'b1, 8'b1111_0001, 1'b0);
        checkOutput("rst_capture", 1'b0, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("rst_y3", 1'b1, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        checkOutput("rst_mid", 1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("rst_after", 1'b0, 3'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_83_hs.md
Name: prio_encoder_83_hs

Overview:
- Sequential 8-to-3 priority encoder; the encode-side counterpart to the team's 3-8 decoder.
- Captures active-low request lines into a sticky pending register.
- Presents the highest-index pending request as a 3-bit code on a valid/ready handshake, and retires that request on acceptance.
- Sits between request/interrupt sources and a consumer that drives a 3-8 decoder or dispatch logic.

Parameters:
- N, 8, number of request lines (power of two, 2..16)
- IDX_W, $clog2(N), width of encoded index; derived, not overridden

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- E  input  1  capture enable, active-high; 0 blocks new request capture only
- In_n  input  N  request lines, active-low (In_n[i]=0 requests index i)
- out_ready  input  1  consumer accepts Y when out_valid=1
- out_valid  output  1  Y holds a valid pending index
- Y  output  IDX_W  encoded index of the presented request
- GS_n  output  1  active-low group signal: 0 when any request is pending or being presented
- ovf  output  1  one-cycle pulse: a request was asserted on an index already pending

Behaviour:
- Reset (rst=1 at clock edge):
  - P (pending register, N bits) = 0; state=IDLE; out_valid=0; Y=0; GS_n=1; ovf=0.
  - rst overrides every other input in the same cycle, including mid-handshake; the presented request is lost.
- Capture, every cycle:
  - set = E ? ~In_n : 0
  - clr = one-hot(Y) when (out_valid & out_ready), else 0
  - P_next = (P & ~clr) | set
  - If set and clr hit the same bit in one cycle, set wins: the bit stays pending and is served again later.
  - Requests are level-sampled: a held-low line re-pends its bit every cycle.
- ovf (registered): ovf_next = |(set & P & ~clr).
- FSM states: IDLE, PRESENT.
  - IDLE: if P != 0 then Y <= index of highest set bit of P (bit N-1 has highest priority), out_valid <= 1, go to PRESENT. Otherwise stay; out_valid=0.
  - PRESENT: Y and out_valid hold stable until out_ready=1. On handshake: clear P[Y], out_valid <= 0, go to IDLE.
  - A higher-priority request arriving during PRESENT never changes Y (valid/data stability rule).
- Latency:
  - In_n low at edge t captured into P at t+1.
  - out_valid=1 from t+2 (IDLE case).
  - Minimum 2 cycles per served request (one IDLE bubble after each handshake).
- GS_n: registered; GS_n_next = ~((P_next != 0) | out_valid_next).
- E=0: no new captures; pending requests are still drained normally.
- Y is don't-care when out_valid=0 but must not toggle; it holds its last value.
- out_ready while out_valid=0 is ignored.
- Width rule: Y is exactly IDX_W bits; no truncation for N a power of two.

Decomposition:
- Shared package enc_pkg:
  - FSM state enum (IDLE, PRESENT)
  - localparam default N=8
  - function prio_idx(vec) returning the highest set index
- One sub-module is natural: prio_enc_comb, a purely combinational N-to-IDX_W highest-bit encoder with an any-bit output. The top level holds P, the FSM and the handshake registers.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, In_n=8'hFF, E=1 -> out_valid=0, GS_n=1, ovf=0, Y=0 for 10 cycles.
- Single request: In_n=8'b1111_1011 for one cycle, out_ready=1 -> out_valid=1 with Y=3'd2 two cycles later, exactly one handshake, then GS_n=1.
- Priority drain: pulse In_n=8'b0101_1110 (bits 7,5,0) for one cycle, out_ready=1 -> Y sequence 7,5,0 on three handshakes, two cycles apart.
- Stability under backpressure: out_ready=0, Y=3'd1 presented; pulse request bit 6 -> Y stays 1 until out_ready=1; next presented Y=6.
- Overflow and set-wins: bit 4 pending and presented; assert In_n[4]=0 on the handshake cycle -> ovf=0 and bit 4 presented again. Assert In_n[4]=0 while pending with no handshake -> ovf=1 for one cycle.
- Enable and mid-op reset: E=0 with In_n=0 -> no capture, out_valid stays 0. With 3 requests pending, assert rst during PRESENT -> next cycle out_valid=0, P=0, GS_n=1.
